// File: rtl/trigger_match.sv
// trigger_match: two mcontrol triggers matching fetch PC or load/store address, with a one-deep request handshake.
// Optional NAPOT match mode (match==1) is built only when KRV_TRIGGER_NAPOT_EN is defined.
module trigger_match (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic [31:0] tdata1_t0,
    input  logic [31:0] tdata1_t1,
    input  logic [31:0] tdata2_t0,
    input  logic [31:0] tdata2_t1,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic        ls_valid,
    input  logic        ls_wr,
    input  logic [31:0] ls_addr,
    input  logic        dbg_mode,
    input  logic        trig_flush,
    output logic        trig_req,
    input  logic        trig_ack,
    output logic        trig_dbg,
    output logic        trig_idx,
    output logic [31:0] trig_tval,
    output logic        trig_hit_set,
    output logic        trig_hit_idx
);

    typedef enum logic {IDLE, PEND} state_t;

    typedef struct packed {
        logic fire;
        logic idx;
        logic dbg;
    } cand_t;

    function automatic logic addr_cmp(input logic [3:0] mode, input logic [31:0] tdata2,
                                      input logic [31:0] addr);
        logic hit;
        hit = 1'b0;
        case (mode)
            4'd0: hit = (addr == tdata2);
`ifdef KRV_TRIGGER_NAPOT_EN
            // tdata2 ^ (tdata2+1) covers bits [k:0] (k = trailing ones); all-ones wraps to a full mask
            4'd1: hit = (((addr ^ tdata2) & ~(tdata2 ^ (tdata2 + 32'd1))) == 32'd0);
`endif
            4'd2: hit = (addr >= tdata2);
            4'd3: hit = (addr < tdata2);
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic armed(input logic [31:0] tdata1, input logic in_debug);
        return (tdata1[31:28] == 4'd2) && tdata1[6] && !in_debug;
    endfunction

    // Pick the winner within one address source; a chained pair reports as trigger 1.
    function automatic cand_t resolve(input logic chain, input logic hit0, input logic hit1,
                                      input logic [3:0] act0, input logic [3:0] act1);
        cand_t c;
        c = '0;
        if (chain) begin
            if (hit0 && hit1 && (act1 <= 4'd1))
                c = '{fire: 1'b1, idx: 1'b1, dbg: (act1 == 4'd1)};
        end else if (hit0 && (act0 <= 4'd1)) begin
            c = '{fire: 1'b1, idx: 1'b0, dbg: (act0 == 4'd1)};
        end else if (hit1 && (act1 <= 4'd1)) begin
            c = '{fire: 1'b1, idx: 1'b1, dbg: (act1 == 4'd1)};
        end
        return c;
    endfunction

    logic [1:0][31:0] td1;
    logic [1:0][31:0] td2;
    logic [1:0]       exe_hit;
    logic [1:0]       ls_hit;
    cand_t            exe_cand;
    cand_t            ls_cand;
    cand_t            sel_cand;
    logic [31:0]      sel_addr;
    state_t           state;
    logic             unused_fields;

    assign td1 = {tdata1_t1, tdata1_t0};
    assign td2 = {tdata2_t1, tdata2_t0};
    assign unused_fields = ^{td1[0][27:16], td1[0][5:3], td1[1][27:16], td1[1][11], td1[1][5:3]};

    always_comb begin
        exe_hit = '0;
        ls_hit  = '0;
        for (int n = 0; n < 2; n++) begin
            exe_hit[n] = armed(td1[n], dbg_mode) && td1[n][2] && if_valid
                         && addr_cmp(td1[n][10:7], td2[n], if_pc);
            ls_hit[n]  = armed(td1[n], dbg_mode) && ls_valid && (ls_wr ? td1[n][1] : td1[n][0])
                         && addr_cmp(td1[n][10:7], td2[n], ls_addr);
        end
    end

    assign exe_cand = resolve(td1[0][11], exe_hit[0], exe_hit[1], td1[0][15:12], td1[1][15:12]);
    assign ls_cand  = resolve(td1[0][11], ls_hit[0], ls_hit[1], td1[0][15:12], td1[1][15:12]);
    assign sel_cand = exe_cand.fire ? exe_cand : ls_cand;
    assign sel_addr = exe_cand.fire ? if_pc : ls_addr;

    // NOTE: every register here, request payload included, is reset so a stale request can never leak out.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state        <= IDLE;
            trig_req     <= 1'b0;
            trig_dbg     <= 1'b0;
            trig_idx     <= 1'b0;
            trig_tval    <= 32'h0;
            trig_hit_set <= 1'b0;
            trig_hit_idx <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            trig_hit_set <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_cand.fire && !trig_flush) begin
                        state        <= PEND;
                        trig_req     <= 1'b1;
                        trig_dbg     <= sel_cand.dbg;
                        trig_idx     <= sel_cand.idx;
                        trig_tval    <= sel_addr;
                        trig_hit_set <= 1'b1;
                        trig_hit_idx <= sel_cand.idx;
                    end
                end
                PEND: begin
                    // New matches are dropped here; flush and ack both retire the request.
                    if (trig_flush || trig_ack) begin
                        state    <= IDLE;
                        trig_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    trig_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_match.sv
// Self-checking bench for trigger_match: directed scenarios plus randomized traffic against a behavioural model.
module tb_trigger_match;

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn;
    logic [31:0] td1 [2];
    logic [31:0] td2 [2];
    logic        if_valid, ls_valid, ls_wr, dbg_mode, trig_flush, trig_ack;
    logic [31:0] if_pc, ls_addr;
    logic        trig_req, trig_dbg, trig_idx, trig_hit_set, trig_hit_idx;
    logic [31:0] trig_tval;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the request register
    bit          m_pend, m_hit, m_dbg, m_idx, m_hidx;
    logic [31:0] m_tval;

    trigger_match dut (
        .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
        .tdata1_t0(td1[0]), .tdata1_t1(td1[1]), .tdata2_t0(td2[0]), .tdata2_t1(td2[1]),
        .if_valid(if_valid), .if_pc(if_pc),
        .ls_valid(ls_valid), .ls_wr(ls_wr), .ls_addr(ls_addr),
        .dbg_mode(dbg_mode), .trig_flush(trig_flush),
        .trig_req(trig_req), .trig_ack(trig_ack), .trig_dbg(trig_dbg), .trig_idx(trig_idx),
        .trig_tval(trig_tval), .trig_hit_set(trig_hit_set), .trig_hit_idx(trig_hit_idx)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] typ, input bit ex, input bit st, input bit ld,
                                       input bit mb, input logic [3:0] act, input logic [3:0] mat,
                                       input bit ch);
        return {typ, 12'h0, act, ch, mat, mb, 3'b0, ex, st, ld};
    endfunction

    function automatic bit m_cmp(input logic [31:0] t1, input logic [31:0] t2, input logic [31:0] a);
        int mode;
        int k;
        mode = int'(t1[10:7]);
        if (mode == 0) return a == t2;
        if (mode == 2) return a >= t2;
        if (mode == 3) return a < t2;
        if (mode == 1) begin
`ifdef KRV_TRIGGER_NAPOT_EN
            k = 0;
            while (k < 32 && t2[k]) k++;
            if (k >= 31) return 1'b1;
            return (a >> (k + 1)) == (t2 >> (k + 1));
`else
            k = 0;
            return 1'b0;
`endif
        end
        return 1'b0;
    endfunction

    function automatic bit m_want(input int n, input bit exec_src);
        logic [31:0] t1;
        t1 = td1[n];
        if (t1[31:28] != 4'd2 || !t1[6] || dbg_mode) return 1'b0;
        if (exec_src) return t1[2] && if_valid && m_cmp(t1, td2[n], if_pc);
        if (!ls_valid) return 1'b0;
        if (ls_wr ? !t1[1] : !t1[0]) return 1'b0;
        return m_cmp(t1, td2[n], ls_addr);
    endfunction

    task automatic m_src(input bit exec_src, output bit fire, output bit idx, output bit dbg);
        fire = 0; idx = 0; dbg = 0;
        if (td1[0][11]) begin
            if (m_want(0, exec_src) && m_want(1, exec_src) && td1[1][15:12] < 4'd2) begin
                fire = 1; idx = 1; dbg = (td1[1][15:12] == 4'd1);
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (!fire && m_want(n, exec_src) && td1[n][15:12] < 4'd2) begin
                    fire = 1; idx = 1'(n); dbg = (td1[n][15:12] == 4'd1);
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("req", {31'b0, trig_req}, {31'b0, m_pend});
        check("hit_set", {31'b0, trig_hit_set}, {31'b0, m_hit});
        if (m_pend) begin
            check("dbg", {31'b0, trig_dbg}, {31'b0, m_dbg});
            check("idx", {31'b0, trig_idx}, {31'b0, m_idx});
            check("tval", trig_tval, m_tval);
        end
        if (m_hit) check("hit_idx", {31'b0, trig_hit_idx}, {31'b0, m_hidx});
    endtask

    // One clock: predict from current inputs, advance, compare just after the edge.
    task automatic step();
        bit f, i, d;
        logic [31:0] a;
        m_src(1'b1, f, i, d);
        a = if_pc;
        if (!f) begin
            m_src(1'b0, f, i, d);
            a = ls_addr;
        end
        @(posedge cpu_clk);
        #1;
        m_hit = 0;
        if (!m_pend) begin
            if (f && !trig_flush) begin
                m_pend = 1; m_hit = 1; m_dbg = d; m_idx = i; m_hidx = i; m_tval = a;
            end
        end else if (trig_flush || trig_ack) begin
            m_pend = 0;
        end
        check_outputs();
    endtask

    task automatic clear_in();
        if_valid = 0; ls_valid = 0; ls_wr = 0; dbg_mode = 0; trig_flush = 0; trig_ack = 0;
    endtask

    // Assert reset away from an edge, verify the immediate clear, release one edge later.
    task automatic do_reset();
        cpu_rstn = 0;
        #2;
        check("rst_req", {31'b0, trig_req}, 32'd0);
        check("rst_dbg", {31'b0, trig_dbg}, 32'd0);
        check("rst_idx", {31'b0, trig_idx}, 32'd0);
        check("rst_tval", trig_tval, 32'h0);
        check("rst_hit", {31'b0, trig_hit_set}, 32'd0);
        check("rst_hidx", {31'b0, trig_hit_idx}, 32'd0);
        m_pend = 0; m_hit = 0;
        @(posedge cpu_clk);
        #1;
        cpu_rstn = 1;
    endtask

    task automatic ack_cycle();
        clear_in();
        trig_ack = 1;
        step();
        trig_ack = 0;
    endtask

    function automatic logic [31:0] pick_td2();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0100;
            1: return 32'h0000_0200;
            2: return 32'h0000_10FF;
            3: return 32'h0000_1000;
            4: return 32'h7FFF_FFFF;
            5: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] base;
        if ($urandom_range(0, 3) == 0) return $urandom;
        base = td2[$urandom_range(0, 1)];
        return base + 32'($urandom_range(0, 8)) - 32'd4;
    endfunction

    task automatic rand_cfg();
        for (int n = 0; n < 2; n++) begin
            td1[n] = mk(($urandom_range(0, 7) == 0) ? 4'd3 : 4'd2, 1'($urandom), 1'($urandom),
                        1'($urandom), $urandom_range(0, 7) != 0, 4'($urandom_range(0, 3)),
                        4'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0));
            td2[n] = pick_td2();
        end
    endtask

    logic [31:0] napot_pc [5];
    logic [31:0] exp_fire;

    initial begin
        cpu_rstn = 0;
        clear_in();
        td1[0] = 0; td1[1] = 0; td2[0] = 0; td2[1] = 0; if_pc = 0; ls_addr = 0;
        m_pend = 0; m_hit = 0; m_dbg = 0; m_idx = 0; m_hidx = 0; m_tval = 0;
        @(posedge cpu_clk); #1;
        check("init_req", {31'b0, trig_req}, 32'd0);
        check("init_tval", trig_tval, 32'h0);
        check("init_hit", {31'b0, trig_hit_set}, 32'd0);
        @(posedge cpu_clk); #1;
        cpu_rstn = 1;

        // Basic execute breakpoint with a held request
        td1[0] = 32'h2000_1044; td2[0] = 32'h0000_0100;
        if_valid = 1; if_pc = 32'h100;
        step();
        check("b_req", {31'b0, trig_req}, 32'd1);
        check("b_dbg", {31'b0, trig_dbg}, 32'd1);
        check("b_idx", {31'b0, trig_idx}, 32'd0);
        check("b_tval", trig_tval, 32'h100);
        check("b_hit", {31'b0, trig_hit_set}, 32'd1);
        if_valid = 0;
        repeat (3) step();
        check("b_hold", {31'b0, trig_req}, 32'd1);
        check("b_hit_once", {31'b0, trig_hit_set}, 32'd0);
        ack_cycle();
        check("b_ack", {31'b0, trig_req}, 32'd0);

        // Source priority: execute beats load
        td1[0] = mk(4'd2, 0, 0, 1, 1, 4'd1, 4'd2, 0); td2[0] = 32'h2000;
        td1[1] = mk(4'd2, 1, 1, 0, 1, 4'd0, 4'd3, 0); td2[1] = 32'h1000;
        if_valid = 1; if_pc = 32'h800; ls_valid = 1; ls_wr = 0; ls_addr = 32'h2004;
        step();
        check("p_idx", {31'b0, trig_idx}, 32'd1);
        check("p_tval", trig_tval, 32'h800);
        check("p_dbg", {31'b0, trig_dbg}, 32'd0);
        ack_cycle();
        ls_valid = 1; ls_wr = 0; ls_addr = 32'h2004;
        step();
        check("l_idx", {31'b0, trig_idx}, 32'd0);
        check("l_tval", trig_tval, 32'h2004);
        ack_cycle();
        ls_valid = 1; ls_wr = 1; ls_addr = 32'h0FFC;
        step();
        check("s_idx", {31'b0, trig_idx}, 32'd1);
        check("s_tval", trig_tval, 32'h0FFC);
        ack_cycle();

        // Chained window 0x100 <= pc < 0x200
        td1[0] = mk(4'd2, 1, 0, 0, 1, 4'd1, 4'd2, 1); td2[0] = 32'h100;
        td1[1] = mk(4'd2, 1, 0, 0, 1, 4'd1, 4'd3, 0); td2[1] = 32'h200;
        if_valid = 1; if_pc = 32'h180;
        step();
        check("c_req", {31'b0, trig_req}, 32'd1);
        check("c_idx", {31'b0, trig_idx}, 32'd1);
        ack_cycle();
        if_valid = 1; if_pc = 32'h080;
        step();
        check("c_lo", {31'b0, trig_req}, 32'd0);
        if_pc = 32'h280;
        step();
        check("c_hi", {31'b0, trig_req}, 32'd0);
        clear_in();

        // Drop in PEND, drop in ack cycle, flush, debug-mode gating, reset mid-PEND
        td1[0] = 32'h2000_1044; td2[0] = 32'h100; td1[1] = 32'h0;
        if_valid = 1; if_pc = 32'h100;
        step();
        step();
        check("d_nohit", {31'b0, trig_hit_set}, 32'd0);
        trig_ack = 1;
        step();
        trig_ack = 0; if_valid = 0;
        step();
        check("d_drop", {31'b0, trig_req}, 32'd0);
        if_valid = 1;
        step();
        if_valid = 0; trig_flush = 1; trig_ack = 1;
        step();
        check("f_pend", {31'b0, trig_req}, 32'd0);
        trig_ack = 0; if_valid = 1;
        step();
        check("f_idle", {31'b0, trig_req}, 32'd0);
        trig_flush = 0; dbg_mode = 1;
        step();
        check("g_dbg", {31'b0, trig_req}, 32'd0);
        dbg_mode = 0;
        step();
        dbg_mode = 1; if_valid = 0;
        step();
        check("g_keep", {31'b0, trig_req}, 32'd1);
        dbg_mode = 0;
        do_reset();
        check("r_clr", {31'b0, trig_req}, 32'd0);
        if_valid = 1;
        step();
        check("r_refire", {31'b0, trig_req}, 32'd1);
        ack_cycle();

        // NAPOT region 0x1000..0x11FF
        td1[0] = mk(4'd2, 1, 0, 0, 1, 4'd1, 4'd1, 0); td2[0] = 32'h0000_10FF;
        napot_pc[0] = 32'h1000; napot_pc[1] = 32'h1100; napot_pc[2] = 32'h11FF;
        napot_pc[3] = 32'h1200; napot_pc[4] = 32'h0FFF;
        for (int j = 0; j < 5; j++) begin
`ifdef KRV_TRIGGER_NAPOT_EN
            exp_fire = (j < 3) ? 32'd1 : 32'd0;
`else
            exp_fire = 32'd0;
`endif
            if_valid = 1; if_pc = napot_pc[j];
            step();
            check("napot", {31'b0, trig_req}, exp_fire);
            ack_cycle();
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 25 == 0) rand_cfg();
            if_valid   = 1'($urandom);
            if_pc      = pick_addr();
            ls_valid   = 1'($urandom);
            ls_wr      = 1'($urandom);
            ls_addr    = pick_addr();
            dbg_mode   = ($urandom_range(0, 9) == 0);
            trig_flush = ($urandom_range(0, 9) == 0);
            trig_ack   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
